// File: rtl/ssd1306_pkg.sv
// Shared constants, command bytes and scanout state encoding for the SSD1306
// framebuffer path.
package ssd1306_pkg;

    localparam int unsigned XSIZE_DEF      = 128;
    localparam int unsigned YSIZE_DEF      = 64;
    localparam int unsigned ADDR_DEPTH_DEF = XSIZE_DEF * YSIZE_DEF / 8;

    localparam logic [7:0] SSD1306_SET_COL_ADDR  = 8'h21;
    localparam logic [7:0] SSD1306_SET_PAGE_ADDR = 8'h22;

    // Full-screen address window: all columns, all 8-row pages
    localparam logic [7:0] COL_START  = 8'h00;
    localparam logic [7:0] COL_END    = 8'(XSIZE_DEF - 1);
    localparam logic [7:0] PAGE_START = 8'h00;
    localparam logic [7:0] PAGE_END   = 8'(YSIZE_DEF / 8 - 1);

    localparam int unsigned PREAMBLE_LEN = 6;
    localparam int unsigned CMD_IDX_W    = 3;
    localparam int unsigned LAT_W        = 2;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        FETCH,
        WAIT,
        SEND,
        DONE
    } scan_state_t;

endpackage

// File: rtl/ssd1306_fb_scanout_if.sv
// Byte stream from the scanout engine to the I2C/SSD1306 transmitter.
interface ssd1306_fb_scanout_if;

    logic [7:0] tx_data;
    logic       tx_dc;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_dc,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_dc,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/ssd1306_preamble_rom.sv
// Address-window preamble lookup: column range then page range covering the
// whole panel.
module ssd1306_preamble_rom
    import ssd1306_pkg::*;
(
    input  logic [CMD_IDX_W-1:0] idx,
    output logic [7:0]           data
);

    always_comb begin
        data = 8'h00;
        case (idx)
            3'd0:    data = SSD1306_SET_COL_ADDR;
            3'd1:    data = COL_START;
            3'd2:    data = COL_END;
            3'd3:    data = SSD1306_SET_PAGE_ADDR;
            3'd4:    data = PAGE_START;
            3'd5:    data = PAGE_END;
            default: data = 8'h00;
        endcase
    end

endmodule

// File: rtl/ssd1306_fb_scanout.sv
// Framebuffer scanout: on a start edge sends the window preamble, then reads
// and streams every framebuffer byte in address order.
module ssd1306_fb_scanout
    import ssd1306_pkg::*;
#(
    parameter int unsigned XSIZE      = XSIZE_DEF,
    parameter int unsigned YSIZE      = YSIZE_DEF,
    parameter int unsigned ADDR_DEPTH = XSIZE * YSIZE / 8,
    parameter int unsigned RD_LATENCY = 1,
    localparam int unsigned ADDR_W    = $clog2(ADDR_DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  gfx_ready,
    output logic                  fb_rd,
    output logic [ADDR_W-1:0]     fb_addr,
    input  logic [7:0]            fb_data,
    ssd1306_fb_scanout_if.master  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam logic [CMD_IDX_W-1:0] CMD_LAST  = CMD_IDX_W'(PREAMBLE_LEN - 1);
    localparam logic [ADDR_W-1:0]    ADDR_LAST = ADDR_W'(ADDR_DEPTH - 1);
    localparam logic [LAT_W-1:0]     LAT_LAST  = LAT_W'(RD_LATENCY);

    scan_state_t          state;
    logic [CMD_IDX_W-1:0] cmd_idx;
    logic [ADDR_W-1:0]    addr;
    logic [LAT_W-1:0]     lat_cnt;
    logic                 start_r;
    logic [7:0]           tx_data_q;
    logic                 tx_dc_q;
    logic                 tx_valid_q;

    logic                 start_req_c;
    logic                 tx_accept_c;
    logic [CMD_IDX_W-1:0] rom_idx_c;
    logic [7:0]           rom_byte_c;

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_dc    = tx_dc_q;
    assign tx.tx_valid = tx_valid_q;

    assign start_req_c = start & ~start_r;
    assign tx_accept_c = tx_valid_q & tx.tx_ready;

    // ROM looks one byte ahead so preamble bytes can go out back-to-back
    always_comb begin
        rom_idx_c = '0;
        if (state == CMD) begin
            rom_idx_c = cmd_idx + CMD_IDX_W'(1);
        end
    end

    ssd1306_preamble_rom u_rom (
        .idx  (rom_idx_c),
        .data (rom_byte_c)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            cmd_idx    <= '0;
            addr       <= '0;
            lat_cnt    <= '0;
            start_r    <= 1'b0;
            fb_rd      <= 1'b0;
            fb_addr    <= '0;
            tx_data_q  <= '0;
            tx_dc_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            start_r    <= start;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_req_c) begin
                        busy       <= 1'b1;
                        cmd_idx    <= '0;
                        tx_data_q  <= rom_byte_c;
                        tx_dc_q    <= 1'b0;
                        tx_valid_q <= 1'b1;
                        state      <= CMD;
                    end
                end
                CMD: begin
                    if (tx_accept_c) begin
                        if (cmd_idx == CMD_LAST) begin
                            tx_valid_q <= 1'b0;
                            addr       <= '0;
                            state      <= FETCH;
                        end else begin
                            cmd_idx   <= cmd_idx + CMD_IDX_W'(1);
                            tx_data_q <= rom_byte_c;
                        end
                    end
                end
                FETCH: begin
                    if (gfx_ready) begin
                        fb_rd   <= 1'b1;
                        fb_addr <= addr;
                        lat_cnt <= '0;
                        state   <= WAIT;
                    end
                end
                // Read is committed once fb_rd is up; gfx_ready is not rechecked
                WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        fb_rd      <= 1'b0;
                        tx_data_q  <= fb_data;
                        tx_dc_q    <= 1'b1;
                        tx_valid_q <= 1'b1;
                        state      <= SEND;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                SEND: begin
                    if (tx_accept_c) begin
                        tx_valid_q <= 1'b0;
                        if (addr == ADDR_LAST) begin
                            addr       <= '0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            addr  <= addr + ADDR_W'(1);
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
